riscv_pipe_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage RISC-V core. Drives the enable and bubble-insert controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. Resolves three hazard types: load-use stalls, taken-branch/jump flushes and multi-cycle data-memory waits. Also provides a memory-timeout flag and a saturating stall counter for debug.

---
 rtl/riscv_pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_riscv_pipe_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RISC-V core: per-stage enables and bubbles,
// with priority memory wait > redirect > load-use, plus timeout flag and stall counter.
module riscv_pipe_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  en_if_id,
    output logic                  en_id_ex,
    output logic                  en_ex_mem,
    output logic                  en_mem_wb,
    output logic                  bubble_if_id,
    output logic                  bubble_id_ex,
    output logic                  redirect_sel,
    output logic                  mem_timeout_err,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic                  dbg_state
);
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    state_t               state_q;
    logic                 pending_q;
    logic [15:0]          wait_cnt_q, wait_cnt_d;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall, load_use, redirect;

    assign mem_stall = mem_req & ~mem_ready;
    assign redirect  = ex_redirect | pending_q;
    assign load_use  = ex_mem_read && (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

    // The release cycle out of MEM_WAIT is evaluated exactly like RUN, so the
    // control outputs need only the stall condition, not the state itself.
    always_comb begin
        pc_en        = 1'b0;
        en_if_id     = 1'b0;
        en_id_ex     = 1'b0;
        en_ex_mem    = 1'b0;
        en_mem_wb    = 1'b0;
        bubble_if_id = 1'b0;
        bubble_id_ex = 1'b0;
        redirect_sel = 1'b0;
        if (reset_n && !mem_stall) begin
            en_id_ex  = 1'b1;
            en_ex_mem = 1'b1;
            en_mem_wb = 1'b1;
            if (redirect) begin
                pc_en        = 1'b1;
                en_if_id     = 1'b1;
                bubble_if_id = 1'b1;
                bubble_id_ex = 1'b1;
                redirect_sel = 1'b1;
            end else if (load_use) begin
                bubble_id_ex = 1'b1;
            end else begin
                pc_en    = 1'b1;
                en_if_id = 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (mem_stall) begin
            if (state_q == RUN)
                wait_cnt_d = 16'd1;
            else if (wait_cnt_q < TIMEOUT)
                wait_cnt_d = wait_cnt_q + 16'd1;
            else
                wait_cnt_d = wait_cnt_q;
        end
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            pending_q   <= 1'b0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            if (mem_stall) begin
                state_q <= MEM_WAIT;
                // A redirect seen while frozen is remembered and issued on release.
                if (ex_redirect)
                    pending_q <= 1'b1;
                if ((state_q == MEM_WAIT) && (wait_cnt_q == TIMEOUT))
                    err_q <= 1'b1;
            end else begin
                state_q <= RUN;
                if (redirect)
                    pending_q <= 1'b0;
            end
        end
    end

    assign mem_timeout_err = err_q;
    assign stall_cnt       = stall_cnt_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl: driver pushes hand-computed expectations,
// monitor pops and compares once per cycle.
module tb_riscv_pipe_ctrl;
    localparam int RW = 5;
    localparam int CW = 32;
    localparam int W  = 1 + 1 + CW + 8;

    // control vector: {pc_en,en_if_id,en_id_ex,en_ex_mem,en_mem_wb,bub_if_id,bub_id_ex,redirect_sel}
    localparam logic [7:0] C_OFF  = 8'b00000_000;
    localparam logic [7:0] C_NORM = 8'b11111_000;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_RED  = 8'b11111_111;
    localparam logic S_RUN  = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_redirect = 0;
    logic          mem_req = 0, mem_ready = 0;
    logic          pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic          bubble_if_id, bubble_id_ex, redirect_sel, mem_timeout_err, dbg_state;
    logic [CW-1:0] stall_cnt;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    riscv_pipe_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
        .bubble_if_id(bubble_if_id), .bubble_id_ex(bubble_id_ex),
        .redirect_sel(redirect_sel), .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue what the DUT must show during that cycle.
    task automatic drive(input logic rst, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic u1, input logic u2, input logic [RW-1:0] rd,
                         input logic mr, input logic redir, input logic req, input logic rdy,
                         input logic [7:0] e_ctrl, input logic e_st, input logic e_err,
                         input int e_cnt);
        @(negedge clk);
        reset_n     = rst;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        ex_rd       = rd;
        ex_mem_read = mr;
        ex_redirect = redir;
        mem_req     = req;
        mem_ready   = rdy;
        exp_q.push_back({e_st, e_err, CW'(e_cnt), e_ctrl});
    endtask

    initial begin : monitor
        logic [W-1:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {dbg_state, mem_timeout_err, stall_cnt,
                         pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                         bubble_if_id, bubble_id_ex, redirect_sel};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL vec%0d {state,err,cnt,ctrl} got %h expected %h",
                             checks, act_v, exp_v);
                end
            end
        end
    end

    initial begin : stimulus
        //     rst rs1 rs2 u1 u2 rd mr rd rq ry  ctrl    state  err cnt
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_OFF,  S_RUN, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, S_RUN, 0, 0);
        // load x5; add x6,x5,x1
        drive(1, 5, 1, 1, 1, 5, 1, 0, 0, 0, C_LU,   S_RUN, 0, 0);
        drive(1, 5, 1, 1, 1, 0, 0, 0, 0, 0, C_NORM, S_RUN, 0, 1);
        // x0 destination never stalls
        drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, C_NORM, S_RUN, 0, 1);
        // rs2 hazard, then same index with rs2 unused
        drive(1, 3, 7, 1, 1, 7, 1, 0, 0, 0, C_LU,   S_RUN, 0, 1);
        drive(1, 3, 7, 1, 0, 7, 1, 0, 0, 0, C_NORM, S_RUN, 0, 2);
        // redirect overrides a simultaneous load-use
        drive(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, C_RED,  S_RUN, 0, 2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, S_RUN, 0, 2);
        // three-cycle memory wait, then release
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_RUN,  0, 2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_WAIT, 0, 3);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_WAIT, 0, 4);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM, S_WAIT, 0, 5);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, S_RUN,  0, 5);
        // redirect during a memory wait is deferred to the release cycle only
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_OFF,  S_RUN,  0, 5);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_WAIT, 0, 6);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RED,  S_WAIT, 0, 7);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, S_RUN,  0, 7);
        // timeout at 4, with a redirect left pending
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_OFF,  S_RUN,  0, 7);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_WAIT, 0, 8);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_WAIT, 0, 9);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_WAIT, 0, 10);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_WAIT, 0, 11);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_WAIT, 1, 12);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_WAIT, 1, 13);
        // asynchronous reset between clock edges
        @(posedge clk);
        #2 reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_OFF,  S_RUN, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, S_RUN, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, S_RUN, 0, 0);
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
